// File: rtl/ysyx_22041412_mdu_iter.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, result held until consumed.
module ysyx_22041412_mdu_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            is_div_i,
  input  logic [2:0]      func3_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [1:0]      dbg_state_o
);

  // Handshakes: a request transfers on a rising edge where valid_i && ready_o && !flush;
  // a result transfers on a rising edge where valid_o && ready_i && !flush.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

  state_t             r_state, w_state_nxt;
  logic [6:0]         r_cnt;
  logic [2*XLEN-1:0]  r_acc;      // mul: partial product; div: {remainder, shifting dividend/quotient}
  logic [2*XLEN-1:0]  r_opa;      // mul: shifting multiplicand magnitude
  logic [XLEN-1:0]    r_opb;      // mul: shifting multiplier; div: divisor magnitude
  logic               r_is_div, r_word, r_hi_sel, r_neg_q, r_neg_r;
  logic [XLEN-1:0]    r_result;

  // Only an encoding where both the family bit and func3[2] agree is treated as a divide.
  logic w_is_div, w_s1_signed, w_s2_signed, w_a_neg, w_b_neg;
  logic w_accept, w_div0, w_ovf, w_special;
  logic [XLEN-1:0] w_a_eff, w_b_eff, w_a_mag, w_b_mag, w_min, w_dividend, w_spec_res;

  assign w_is_div    = is_div_i & func3_i[2];
  assign w_s1_signed = w_is_div ? ~func3_i[0] : (func3_i[1:0] != 2'b11);
  assign w_s2_signed = w_is_div ? ~func3_i[0] : ~func3_i[1];

  assign w_a_eff = word_i ? (w_s1_signed ? {{32{src1_i[31]}}, src1_i[31:0]} : {32'b0, src1_i[31:0]})
                          : src1_i;
  assign w_b_eff = word_i ? (w_s2_signed ? {{32{src2_i[31]}}, src2_i[31:0]} : {32'b0, src2_i[31:0]})
                          : src2_i;
  assign w_a_neg = w_s1_signed & w_a_eff[XLEN-1];
  assign w_b_neg = w_s2_signed & w_b_eff[XLEN-1];
  assign w_a_mag = w_a_neg ? -w_a_eff : w_a_eff;
  assign w_b_mag = w_b_neg ? -w_b_eff : w_b_eff;

  // Divide-by-zero and min/-1 finish without iterating; min is taken at the effective width.
  assign w_min      = word_i ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
  assign w_dividend = word_i ? {{32{src1_i[31]}}, src1_i[31:0]} : src1_i;
  assign w_div0     = w_is_div & (w_b_eff == '0);
  assign w_ovf      = w_is_div & ~func3_i[0] & (w_a_eff == w_min) & (w_b_eff == '1);
  assign w_special  = w_div0 | w_ovf;
  assign w_spec_res = w_div0 ? (func3_i[1] ? w_dividend : '1)
                             : (func3_i[1] ? '0 : w_dividend);

  assign ready_o     = (r_state == S_IDLE);
  assign valid_o     = (r_state == S_DONE);
  assign result_o    = r_result;
  assign dbg_state_o = r_state;
  assign w_accept    = valid_i & ready_o & ~flush;

  // One iteration of either datapath.
  logic [2*XLEN-1:0] w_mul_acc, w_acc_nxt, w_prod_fin;
  logic [XLEN:0]     w_rs;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_nxt, w_q_nxt, w_q_fin, w_r_fin, w_raw, w_final;

  assign w_mul_acc = r_acc + (r_opb[0] ? r_opa : '0);
  assign w_rs      = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_ge      = (w_rs >= {1'b0, r_opb});
  assign w_rem_nxt = w_ge ? (w_rs[XLEN-1:0] - r_opb) : w_rs[XLEN-1:0];
  assign w_q_nxt   = {r_acc[XLEN-2:0], w_ge};
  assign w_acc_nxt = r_is_div ? {w_rem_nxt, w_q_nxt} : w_mul_acc;

  assign w_prod_fin = r_neg_q ? -w_mul_acc : w_mul_acc;
  assign w_q_fin    = r_neg_q ? -w_q_nxt : w_q_nxt;
  assign w_r_fin    = r_neg_r ? -w_rem_nxt : w_rem_nxt;
  assign w_raw      = r_is_div ? (r_hi_sel ? w_r_fin : w_q_fin)
                               : (r_hi_sel ? w_prod_fin[2*XLEN-1:XLEN] : w_prod_fin[XLEN-1:0]);
  assign w_final    = r_word ? {{32{w_raw[31]}}, w_raw[31:0]} : w_raw;

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
        S_CALC: if (r_cnt == 7'd1) w_state_nxt = S_DONE;
        S_DONE: if (ready_i) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_is_div <= 1'b0;
      r_word   <= 1'b0;
      r_hi_sel <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_cnt    <= word_i ? 7'd32 : 7'd64;
      r_is_div <= w_is_div;
      r_word   <= word_i;
      r_hi_sel <= w_is_div ? func3_i[1] : (func3_i[1:0] != 2'b00);
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_opa    <= {{XLEN{1'b0}}, w_a_mag};
      r_opb    <= w_b_mag;
      // Word dividends are pre-shifted so the first of 32 iterations sees their top bit.
      r_acc    <= w_is_div ? {{XLEN{1'b0}}, (word_i ? {w_a_mag[31:0], 32'b0} : w_a_mag)} : '0;
      if (w_special) r_result <= w_spec_res;
    end else if (r_state == S_CALC && !flush) begin
      r_cnt <= r_cnt - 7'd1;
      r_acc <= w_acc_nxt;
      r_opa <= r_opa << 1;
      if (!r_is_div) r_opb <= r_opb >> 1;
      if (r_cnt == 7'd1) r_result <= w_final;
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_mdu_iter.sv
// Bench for ysyx_22041412_mdu_iter: directed RV64M vectors, backpressure, flush,
// mid-operation reset and a randomised run scored against a behavioural model.
module tb_ysyx_22041412_mdu_iter;

  logic        clk = 1'b0;
  logic        rst, flush, valid_i, ready_o, is_div_i, word_i, valid_o, ready_i;
  logic [2:0]  func3_i;
  logic [63:0] src1_i, src2_i, result_o;
  logic [1:0]  dbg_state_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];

  ysyx_22041412_mdu_iter #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_i(valid_i), .ready_o(ready_o),
    .is_div_i(is_div_i), .func3_i(func3_i), .word_i(word_i), .src1_i(src1_i),
    .src2_i(src2_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .dbg_state_o(dbg_state_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Behavioural reference: result and accept-to-valid latency.
  task automatic model(input logic d, input logic [2:0] f, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] r, output int lat);
    logic s1, s2, is_rem;
    logic [63:0] ea, eb, mn;
    logic [127:0] xa, xb, p;
    longint sa, sb;
    if (!d) begin
      s1 = (f != 3'd3);
      s2 = (f == 3'd0) || (f == 3'd1);
    end else begin
      s1 = (f == 3'd4) || (f == 3'd6);
      s2 = s1;
    end
    is_rem = (f == 3'd6) || (f == 3'd7);
    ea = w ? (s1 ? sx32(a[31:0]) : {32'b0, a[31:0]}) : a;
    eb = w ? (s2 ? sx32(b[31:0]) : {32'b0, b[31:0]}) : b;
    mn = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    lat = w ? 33 : 65;
    if (!d) begin
      xa = s1 ? {{64{ea[63]}}, ea} : {64'b0, ea};
      xb = s2 ? {{64{eb[63]}}, eb} : {64'b0, eb};
      p  = xa * xb;
      r  = (f == 3'd0) ? p[63:0] : p[127:64];
    end else if (eb == 64'd0) begin
      r   = is_rem ? ea : 64'hFFFF_FFFF_FFFF_FFFF;
      lat = 1;
    end else if (s1 && ea == mn && eb == 64'hFFFF_FFFF_FFFF_FFFF) begin
      r   = is_rem ? 64'd0 : ea;
      lat = 1;
    end else if (s1) begin
      sa = ea;
      sb = eb;
      r  = is_rem ? sa % sb : sa / sb;
    end else begin
      r = is_rem ? ea % eb : ea / eb;
    end
    if (w) r = sx32(r[31:0]);
  endtask

  // driver: one request, then collect its result (optionally with ready_i held low)
  task automatic run_op(input string tag, input logic d, input logic [2:0] f, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_lat, input int hold);
    int t;
    int lat;
    logic [63:0] got;
    t = 0;
    while (!ready_o && t < 200) begin
      @(posedge clk); #1; t++;
    end
    check({tag, "_ready_before"}, {63'b0, ready_o}, 64'd1);
    exp_q.push_back(exp);
    is_div_i = d; func3_i = f; word_i = w; src1_i = a; src2_i = b; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    src1_i = {$urandom, $urandom};
    src2_i = {$urandom, $urandom};
    func3_i = 3'($urandom_range(0, 7));
    word_i = 1'($urandom_range(0, 1));
    lat = 1;
    while (!valid_o && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    got = exp_q.pop_front();
    if (valid_o) begin
      check(tag, result_o, got);
      got = result_o;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check({tag, "_hold_valid"}, {63'b0, valid_o}, 64'd1);
        check({tag, "_hold_result"}, result_o, got);
        check({tag, "_hold_ready"}, {63'b0, ready_o}, 64'd0);
      end
      ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0;
      check({tag, "_after_valid"}, {63'b0, valid_o}, 64'd0);
      check({tag, "_after_ready"}, {63'b0, ready_o}, 64'd1);
    end
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'($urandom_range(0, 20));
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return {$urandom, 32'h8000_0000};
      5: return {32'h0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] r;
    int          lat;
    logic        seen;
    logic        d, w;
    logic [2:0]  f;
    logic [63:0] a, b;

    // reset
    rst = 1'b0; flush = 1'b0; valid_i = 1'b0; ready_i = 1'b0; is_div_i = 1'b0;
    func3_i = 3'd0; word_i = 1'b0; src1_i = '0; src2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {63'b0, ready_o}, 64'd1);
    check("reset_valid", {63'b0, valid_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_state", {62'b0, dbg_state_o}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // directed vectors
    run_op("mul_7_m3", 0, 3'd0, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
    run_op("mulhu_ones", 0, 3'd3, 0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
    run_op("mulh_ones", 0, 3'd1, 0, '1, '1, 64'd0, 65, 0);
    run_op("mulhsu_m1_2", 0, 3'd2, 0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("div_by0", 1, 3'd4, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("rem_by0", 1, 3'd6, 0, 64'd5, 64'd0, 64'd5, 1, 0);
    run_op("div_ovf", 1, 3'd4, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0);
    run_op("rem_ovf", 1, 3'd6, 0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0);
    run_op("divw_ovf", 1, 3'd4, 1, 64'h1234_5678_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("div_m7_2", 1, 3'd4, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    run_op("rem_m7_2", 1, 3'd6, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("remuw_10", 1, 3'd7, 1, '1, 64'd10, 64'd5, 33, 0);
    run_op("mulw_hold", 0, 3'd0, 1, 64'hABCD_0000_0001_2345, '1, 64'hFFFF_FFFF_FFFE_DCBB, 33, 10);

    // flush beats a simultaneous request in IDLE
    is_div_i = 1'b0; func3_i = 3'd0; word_i = 1'b0; src1_i = 64'd9; src2_i = 64'd9;
    valid_i = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; flush = 1'b0;
    check("flush_vs_valid_state", {62'b0, dbg_state_o}, 64'd0);

    // flush during CALC cycle 20
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("flush_pre_state", {62'b0, dbg_state_o}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_state", {62'b0, dbg_state_o}, 64'd0);
    check("flush_ready", {63'b0, ready_o}, 64'd1);
    check("flush_valid", {63'b0, valid_o}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (valid_o) seen = 1'b1;
    end
    check("flush_no_result", {63'b0, seen}, 64'd0);
    run_op("mul_3_4", 0, 3'd0, 0, 64'd3, 64'd4, 64'd12, 65, 0);

    // asynchronous reset mid-CALC
    is_div_i = 1'b1; func3_i = 3'd5; word_i = 1'b0; src1_i = 64'd100; src2_i = 64'd7;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midrst_ready", {63'b0, ready_o}, 64'd1);
    check("midrst_valid", {63'b0, valid_o}, 64'd0);
    check("midrst_result", result_o, 64'd0);
    check("midrst_state", {62'b0, dbg_state_o}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // randomised ops against the model
    for (int n = 0; n < 24; n++) begin
      d = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      f = d ? {1'b1, 2'($urandom_range(0, 3))} : {1'b0, 2'($urandom_range(0, 3))};
      if (!d && w) f = 3'd0;
      a = rnd64();
      b = rnd64();
      model(d, f, w, a, b, r, lat);
      run_op($sformatf("rand%0d_d%0d_f%0d_w%0d", n, d, f, w), d, f, w, a, b, r, lat,
             int'($urandom_range(0, 2)));
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
